// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// FSM state encoding plus default baud/timeout figures used alongside tx_module.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int CLK_HZ      = 50_000_000;
  localparam int BAUD        = 9600;
  localparam int DEF_TIMEOUT = 65535;
  localparam int DEF_TMO_W   = 17;
  localparam int GRANT_W     = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit after last, with wrap.
// Ports: req (requests), last (previous grant) -> valid (any req), grant (index).
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last,
  output logic               valid,
  output logic [GRANT_W-1:0] grant
);

  int idx;

  // Scan from farthest to nearest so the nearest set bit after
  // last is written last and wins.
  always_comb begin
    valid = |req;
    grant = last;
    idx   = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (req[idx]) grant = GRANT_W'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one tx_module among NUM_REQ byte producers.
// Ports: CLK/RST, Req/Req_Data in, Req_Ack/Req_Err/Grant_Id/Busy out, Tx_* to tx_module.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TMO_W      = DEF_TMO_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  output logic [NUM_REQ-1:0]        Req_Ack,
  output logic [NUM_REQ-1:0]        Req_Err,
  output logic [GRANT_W-1:0]        Grant_Id,
  output logic                      Busy,
  output logic                      Tx_En_Sig,
  output logic [DATA_W-1:0]         Tx_Data,
  input  logic                      Tx_Done_Sig
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state;
  logic [GRANT_W-1:0] last;
  logic [TMO_W-1:0]   tmo;
  logic [GAP_W-1:0]   gcnt;
  logic               arb_valid;
  logic [GRANT_W-1:0] arb_grant;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req  (Req),
    .last (last),
    .valid(arb_valid),
    .grant(arb_grant)
  );

  assign Busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last      <= GRANT_W'(NUM_REQ - 1);
      Grant_Id  <= '0;
      Tx_En_Sig <= 1'b0;
      Tx_Data   <= '0;
      Req_Ack   <= '0;
      Req_Err   <= '0;
      tmo       <= '0;
      gcnt      <= '0;
    end else begin
      Req_Ack <= '0;
      Req_Err <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            Grant_Id <= arb_grant;
            last     <= arb_grant;
            Tx_Data  <= Req_Data[int'(arb_grant)*DATA_W +: DATA_W];
            state    <= LOAD;
          end
        end
        LOAD: begin
          Tx_En_Sig <= 1'b1;
          tmo       <= '0;
          state     <= SEND;
        end
        SEND: begin
          // Done is tested first so it wins over a coincident timeout.
          if (Tx_Done_Sig) begin
            Tx_En_Sig <= 1'b0;
            Req_Ack   <= NUM_REQ'(1) << Grant_Id;
            gcnt      <= '0;
            state     <= GAP;
          end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
            Tx_En_Sig <= 1'b0;
            Req_Err   <= NUM_REQ'(1) << Grant_Id;
            gcnt      <= '0;
            state     <= GAP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == GAP_W'(GAP_CYCLES - 1)) state <= IDLE;
          else gcnt <= gcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a Tx_Done_Sig model and
// a frame scoreboard (expected grant/byte/outcome queued at request time).
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int TMO = 200;
  localparam int TW  = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [NR-1:0]  Req = '0;
  logic [NR*DW-1:0] Req_Data = '0;
  logic [NR-1:0]  Req_Ack;
  logic [NR-1:0]  Req_Err;
  logic [2:0]     Grant_Id;
  logic           Busy;
  logic           Tx_En_Sig;
  logic [DW-1:0]  Tx_Data;
  logic           Tx_Done_Sig;
  logic           done_m = 1'b0;
  logic           done_f = 1'b0;

  assign Tx_Done_Sig = done_m | done_f;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAP),
    .TIMEOUT(TMO), .TMO_W(TW)
  ) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Req_Data(Req_Data),
    .Req_Ack(Req_Ack), .Req_Err(Req_Err), .Grant_Id(Grant_Id),
    .Busy(Busy), .Tx_En_Sig(Tx_En_Sig), .Tx_Data(Tx_Data),
    .Tx_Done_Sig(Tx_Done_Sig)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int done_delay = -1;
  int en_cnt = 0;

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
    bit         err;
  } exp_t;

  exp_t sb[$];

  function automatic void push(input logic [2:0] id,
                               input logic [7:0] data,
                               input bit err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    sb.push_back(e);
  endfunction

  // Done model: pulses done when the enable has been high for done_delay+1 cycles.
  initial forever begin
    @(negedge CLK);
    done_m = 1'b0;
    if (Tx_En_Sig && done_delay >= 0) begin
      if (en_cnt == done_delay) done_m = 1'b1;
      en_cnt++;
    end else begin
      en_cnt = 0;
    end
  end

  // Scoreboard monitor: frame start and frame outcome against queue head.
  initial begin
    logic       prev_en;
    int         low_run;
    logic [3:0] ea, ee;
    prev_en = 1'b0;
    low_run = 1000;
    forever begin
      @(negedge CLK);
      if (Tx_En_Sig && !prev_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL frame_start unexpected grant=%0d data=%h", Grant_Id, Tx_Data);
        end else if (Grant_Id !== sb[0].id || Tx_Data !== sb[0].data) begin
          errors++;
          $display("FAIL frame_start got grant=%0d data=%h exp grant=%0d data=%h",
                   Grant_Id, Tx_Data, sb[0].id, sb[0].data);
        end
        checks++;
        if (low_run < GAP) begin
          errors++;
          $display("FAIL gap_len got=%0d exp>=%0d", low_run, GAP);
        end
      end
      if ((Req_Ack | Req_Err) != 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL outcome unexpected ack=%b err=%b", Req_Ack, Req_Err);
        end else begin
          ea = sb[0].err ? 4'b0 : (4'(1) << sb[0].id);
          ee = sb[0].err ? (4'(1) << sb[0].id) : 4'b0;
          if (Req_Ack !== ea || Req_Err !== ee) begin
            errors++;
            $display("FAIL outcome got ack=%b err=%b exp ack=%b err=%b",
                     Req_Ack, Req_Err, ea, ee);
          end
          void'(sb.pop_front());
        end
      end
      low_run = Tx_En_Sig ? 0 : low_run + 1;
      prev_en = Tx_En_Sig;
    end
  end

  task automatic test_reset();
    RST = 1'b1;
    Req = '0;
    sb.delete();
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (Tx_En_Sig !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", Tx_En_Sig); end
    checks++;
    if (Tx_Data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", Tx_Data); end
    checks++;
    if (Req_Ack !== 4'b0 || Req_Err !== 4'b0) begin
      errors++; $display("FAIL reset_ack_err got ack=%b err=%b exp=0", Req_Ack, Req_Err);
    end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++;
    if (Grant_Id !== 3'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", Grant_Id); end
    RST = 1'b0;
  endtask

  task automatic test_single();
    int n;
    done_delay = 3;
    Req_Data[7:0] = 8'h2E;
    push(3'd0, 8'h2E, 1'b0);
    Req = 4'b0001;
    @(negedge CLK);
    checks++;
    if (Tx_En_Sig !== 1'b0 || Busy !== 1'b1) begin
      errors++; $display("FAIL single_load got en=%b busy=%b exp en=0 busy=1", Tx_En_Sig, Busy);
    end
    @(negedge CLK);
    checks++;
    if (Tx_En_Sig !== 1'b1 || Tx_Data !== 8'h2E) begin
      errors++; $display("FAIL single_latency got en=%b data=%h exp en=1 data=2e", Tx_En_Sig, Tx_Data);
    end
    n = 0;
    while (Req_Ack == 4'b0 && n < 50) begin @(negedge CLK); n++; end
    checks++;
    if (Req_Ack !== 4'b0001 || Tx_En_Sig !== 1'b0) begin
      errors++; $display("FAIL single_ack got ack=%b en=%b exp ack=0001 en=0", Req_Ack, Tx_En_Sig);
    end
    Req = '0;
    @(negedge CLK);
    checks++;
    if (Req_Ack !== 4'b0 || Busy !== 1'b1 || Tx_En_Sig !== 1'b0) begin
      errors++; $display("FAIL single_gap got ack=%b busy=%b en=%b exp 0000/1/0", Req_Ack, Busy, Tx_En_Sig);
    end
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || Tx_En_Sig !== 1'b0) begin
      errors++; $display("FAIL single_idle got busy=%b en=%b exp 0/0", Busy, Tx_En_Sig);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_round_robin();
    int acks, cyc, frames, low;
    logic prev;
    RST = 1'b1;
    sb.delete();
    @(negedge CLK);
    RST = 1'b0;
    done_delay = 1;
    Req_Data = {8'h55, 8'hDD, 8'h3F, 8'h2E};
    push(3'd0, 8'h2E, 1'b0);
    push(3'd1, 8'h3F, 1'b0);
    push(3'd2, 8'hDD, 1'b0);
    push(3'd3, 8'h55, 1'b0);
    push(3'd0, 8'h2E, 1'b0);
    Req = 4'b1111;
    acks = 0; cyc = 0; frames = 0; low = 0; prev = 1'b0;
    while (acks < 5 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (Tx_En_Sig && !prev) begin
        if (frames > 0) begin
          checks++;
          if (low !== GAP + 2) begin
            errors++; $display("FAIL rr_gap got=%0d exp=%0d", low, GAP + 2);
          end
        end
        frames++;
      end
      low = Tx_En_Sig ? 0 : low + 1;
      prev = Tx_En_Sig;
      if (Req_Ack != 4'b0) acks++;
      if (acks == 5) Req = '0;
    end
    Req = '0;
    checks++;
    if (acks != 5) begin errors++; $display("FAIL rr_acks got=%0d exp=5", acks); end
    repeat (8) @(negedge CLK);
    checks++;
    if (sb.size() != 0 || Tx_En_Sig !== 1'b0) begin
      errors++; $display("FAIL rr_drain got pending=%0d en=%b exp 0/0", sb.size(), Tx_En_Sig);
    end
  endtask

  task automatic test_timeout();
    int n;
    done_delay = -1;
    Req_Data[23:16] = 8'hA5;
    push(3'd2, 8'hA5, 1'b1);
    Req = 4'b0100;
    n = 0;
    while (!Tx_En_Sig && n < 10) begin @(negedge CLK); n++; end
    checks++;
    if (Tx_En_Sig !== 1'b1) begin errors++; $display("FAIL tmo_start got en=%b exp=1", Tx_En_Sig); end
    n = 0;
    while (Tx_En_Sig && n < TMO + 10) begin n++; @(negedge CLK); end
    checks++;
    if (n != TMO) begin errors++; $display("FAIL tmo_len got=%0d exp=%0d", n, TMO); end
    checks++;
    if (Req_Err !== 4'b0100 || Req_Ack !== 4'b0 || Tx_En_Sig !== 1'b0) begin
      errors++; $display("FAIL tmo_err got err=%b ack=%b en=%b exp 0100/0000/0", Req_Err, Req_Ack, Tx_En_Sig);
    end
    Req = '0;
    repeat (4) @(negedge CLK);
    done_delay = 2;
    Req_Data[15:8] = 8'h3C;
    push(3'd1, 8'h3C, 1'b0);
    Req = 4'b0010;
    n = 0;
    while (Req_Ack == 4'b0 && n < 50) begin @(negedge CLK); n++; end
    checks++;
    if (Req_Ack !== 4'b0010) begin errors++; $display("FAIL tmo_next got ack=%b exp=0010", Req_Ack); end
    Req = '0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_done_at_timeout();
    int n;
    done_delay = TMO - 1;
    Req_Data[31:24] = 8'h5A;
    push(3'd3, 8'h5A, 1'b0);
    Req = 4'b1000;
    n = 0;
    while ((Req_Ack | Req_Err) == 4'b0 && n < TMO + 20) begin @(negedge CLK); n++; end
    checks++;
    if (Req_Ack !== 4'b1000 || Req_Err !== 4'b0) begin
      errors++; $display("FAIL done_tmo got ack=%b err=%b exp ack=1000 err=0000", Req_Ack, Req_Err);
    end
    Req = '0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset_mid_send();
    int n, acks;
    bit first;
    done_delay = -1;
    Req_Data[7:0] = 8'h3F;
    push(3'd0, 8'h3F, 1'b0);
    Req = 4'b0001;
    n = 0;
    while (!Tx_En_Sig && n < 10) begin @(negedge CLK); n++; end
    checks++;
    if (Tx_En_Sig !== 1'b1 || Tx_Data !== 8'h3F) begin
      errors++; $display("FAIL rst_mid_start got en=%b data=%h exp 1/3f", Tx_En_Sig, Tx_Data);
    end
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    sb.delete();
    Req = 4'b0011;
    Req_Data[15:8] = 8'h77;
    done_delay = 1;
    @(negedge CLK);
    checks++;
    if (Tx_En_Sig !== 1'b0 || Busy !== 1'b0 || Req_Ack !== 4'b0 || Req_Err !== 4'b0) begin
      errors++; $display("FAIL rst_mid_drop got en=%b busy=%b ack=%b err=%b exp 0/0/0/0",
                         Tx_En_Sig, Busy, Req_Ack, Req_Err);
    end
    push(3'd0, 8'h3F, 1'b0);
    push(3'd1, 8'h77, 1'b0);
    RST = 1'b0;
    acks = 0; n = 0; first = 1'b1;
    while (acks < 2 && n < 100) begin
      @(negedge CLK);
      n++;
      if (Tx_En_Sig && first) begin
        first = 1'b0;
        checks++;
        if (Grant_Id !== 3'd0) begin errors++; $display("FAIL rst_first_grant got=%0d exp=0", Grant_Id); end
      end
      if (Req_Ack != 4'b0) acks++;
      if (acks == 2) Req = '0;
    end
    Req = '0;
    checks++;
    if (acks != 2) begin errors++; $display("FAIL rst_mid_acks got=%0d exp=2", acks); end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_spurious();
    int n;
    done_f = 1'b1;
    @(negedge CLK);
    done_f = 1'b0;
    checks++;
    if (Req_Ack !== 4'b0 || Busy !== 1'b0 || Tx_En_Sig !== 1'b0) begin
      errors++; $display("FAIL spur_idle got ack=%b busy=%b en=%b exp 0000/0/0", Req_Ack, Busy, Tx_En_Sig);
    end
    done_delay = 4;
    Req_Data[23:16] = 8'hC3;
    push(3'd2, 8'hC3, 1'b0);
    Req = 4'b0100;
    n = 0;
    while (!Tx_En_Sig && n < 10) begin @(negedge CLK); n++; end
    Req = '0;
    n = 0;
    while (Req_Ack == 4'b0 && n < 50) begin @(negedge CLK); n++; end
    checks++;
    if (Req_Ack !== 4'b0100) begin errors++; $display("FAIL drop_ack got=%b exp=0100", Req_Ack); end
    done_f = 1'b1;
    @(negedge CLK);
    done_f = 1'b0;
    checks++;
    if (Req_Ack !== 4'b0 || Busy !== 1'b1 || Tx_En_Sig !== 1'b0) begin
      errors++; $display("FAIL spur_gap got ack=%b busy=%b en=%b exp 0000/1/0", Req_Ack, Busy, Tx_En_Sig);
    end
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || Req_Ack !== 4'b0) begin
      errors++; $display("FAIL spur_after got busy=%b ack=%b exp 0/0000", Busy, Req_Ack);
    end
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_send();
    test_spurious();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
